// File: rtl/ahbl_mtimer_pkg.sv
// Shared constants for the AHB-Lite multi-channel timer: register map,
// control/status bit positions and legal configuration limits.
package ahbl_mtimer_pkg;

  localparam int NCH_MIN = 1;
  localparam int NCH_MAX = 8;
  localparam int CW_MIN  = 8;
  localparam int CW_MAX  = 32;

  // Per-channel register offsets within each 0x10-byte channel window
  localparam logic [3:0] OFF_CTRL  = 4'h0;
  localparam logic [3:0] OFF_LOAD  = 4'h4;
  localparam logic [3:0] OFF_COUNT = 4'h8;
  localparam logic [3:0] OFF_STAT  = 4'hC;

  localparam logic [7:0] ADDR_PRESCALE = 8'h80;
  localparam logic [7:0] ADDR_IRQSTAT  = 8'h84;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IE   = 2;
  localparam int STAT_EXP  = 0;

  localparam logic [31:0] RDATA_BAD = 32'hBADD_BEEF;

endpackage

// File: rtl/ahbl_mtimer_ch.sv
// One timer channel: control bits, reload value, down-counter and sticky
// expiry flag. Advances only on the shared prescaler tick.
module ahbl_mtimer_ch
  import ahbl_mtimer_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          tick,
  input  logic          wr_ctrl,
  input  logic          wr_load,
  input  logic          wr_stat,
  input  logic [CW-1:0] wdata,
  output logic          en,
  output logic          mode,
  output logic          ie,
  output logic          exp,
  output logic [CW-1:0] load,
  output logic [CW-1:0] count
);

  logic          en_q, en_d, mode_q, mode_d, ie_q, ie_d, exp_q, exp_d;
  logic [CW-1:0] load_q, load_d, count_q, count_d;
  logic          en_eff, start, run, expire;

  always_comb begin
    // A CTRL write takes effect this cycle, so EN=0 blocks a coincident tick
    en_eff = wr_ctrl ? wdata[CTRL_EN] : en_q;
    mode_d = wr_ctrl ? wdata[CTRL_MODE] : mode_q;
    ie_d   = wr_ctrl ? wdata[CTRL_IE] : ie_q;
    start  = wr_ctrl && wdata[CTRL_EN] && !en_q;
    run    = tick && en_eff && !start;
    expire = run && (count_q == '0);
    load_d = wr_load ? wdata : load_q;
    en_d    = en_eff;
    count_d = count_q;
    if (start) begin
      count_d = load_q;
    end else if (run) begin
      if (expire) begin
        if (mode_d) count_d = load_q;
        else        en_d    = 1'b0;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
    exp_d = exp_q;
    if (wr_stat && wdata[STAT_EXP]) exp_d = 1'b0;
    if (expire)                     exp_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q    <= 1'b0;
      mode_q  <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
    end else begin
      en_q    <= en_d;
      mode_q  <= mode_d;
      ie_q    <= ie_d;
      exp_q   <= exp_d;
      load_q  <= load_d;
      count_q <= count_d;
    end
  end

  assign en    = en_q;
  assign mode  = mode_q;
  assign ie    = ie_q;
  assign exp   = exp_q;
  assign load  = load_q;
  assign count = count_q;

endmodule

// File: rtl/ahbl_mtimer.sv
// AHB-Lite slave wrapping NCH independent down-counting timers that share
// one prescaler; zero wait states, reads decoded from the registered address.
module ahbl_mtimer
  import ahbl_mtimer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 32,
  parameter int PW  = 16
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  input  logic [31:0]    HADDR,
  input  logic [1:0]     HTRANS,
  input  logic           HREADY,
  input  logic [2:0]     HSIZE,
  input  logic           HWRITE,
  input  logic           HSEL,
  input  logic [31:0]    HWDATA,
  output logic           HREADYOUT,
  output logic [31:0]    HRDATA,
  output logic [NCH-1:0] IRQ,
  output logic           IRQ_ANY
);

  if (NCH < NCH_MIN || NCH > NCH_MAX || CW < CW_MIN || CW > CW_MAX) begin : g_bad_cfg
    $error("ahbl_mtimer: NCH or CW out of range");
  end

  logic       sel_q, sel_d, write_q, write_d, trans_q, trans_d;
  logic [7:0] addr_q, addr_d;

  always_comb begin
    sel_d   = sel_q;
    write_d = write_q;
    trans_d = trans_q;
    addr_d  = addr_q;
    if (HREADY) begin
      sel_d   = HSEL;
      write_d = HWRITE;
      trans_d = HTRANS[1];
      addr_d  = HADDR[7:0];
    end
  end

  logic       wr_en, ch_area, wr_pre, tick;
  logic [2:0] ch_idx;
  logic [3:0] ch_off;

  assign wr_en   = sel_q && trans_q && write_q;
  assign ch_idx  = addr_q[6:4];
  assign ch_off  = addr_q[3:0];
  assign ch_area = !addr_q[7] && (int'(ch_idx) < NCH);
  assign wr_pre  = wr_en && (addr_q == ADDR_PRESCALE);

  // Shared prescaler: restarts from zero whenever PRESCALE is rewritten
  logic [PW-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;

  assign tick = (pcnt_q == prescale_q);

  always_comb begin
    prescale_d = wr_pre ? HWDATA[PW-1:0] : prescale_q;
    pcnt_d     = (wr_pre || tick) ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q      <= 1'b0;
      write_q    <= 1'b0;
      trans_q    <= 1'b0;
      addr_q     <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      sel_q      <= sel_d;
      write_q    <= write_d;
      trans_q    <= trans_d;
      addr_q     <= addr_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end

  logic [NCH-1:0] en, mode, ie, exp;
  logic [CW-1:0]  load  [NCH];
  logic [CW-1:0]  count [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr_ch;
    assign wr_ch = wr_en && ch_area && (ch_idx == 3'(i));
    ahbl_mtimer_ch #(.CW(CW)) u_ch (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .tick    (tick),
      .wr_ctrl (wr_ch && (ch_off == OFF_CTRL)),
      .wr_load (wr_ch && (ch_off == OFF_LOAD)),
      .wr_stat (wr_ch && (ch_off == OFF_STAT)),
      .wdata   (HWDATA[CW-1:0]),
      .en      (en[i]),
      .mode    (mode[i]),
      .ie      (ie[i]),
      .exp     (exp[i]),
      .load    (load[i]),
      .count   (count[i])
    );
  end

  always_comb begin
    HRDATA = RDATA_BAD;
    if (ch_area) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_idx == 3'(i)) begin
          case (ch_off)
            OFF_CTRL: begin
              HRDATA            = '0;
              HRDATA[CTRL_EN]   = en[i];
              HRDATA[CTRL_MODE] = mode[i];
              HRDATA[CTRL_IE]   = ie[i];
            end
            OFF_LOAD: begin
              HRDATA         = '0;
              HRDATA[CW-1:0] = load[i];
            end
            OFF_COUNT: begin
              HRDATA         = '0;
              HRDATA[CW-1:0] = count[i];
            end
            OFF_STAT: begin
              HRDATA           = '0;
              HRDATA[STAT_EXP] = exp[i];
            end
            default: HRDATA = RDATA_BAD;
          endcase
        end
      end
    end else if (addr_q == ADDR_PRESCALE) begin
      HRDATA         = '0;
      HRDATA[PW-1:0] = prescale_q;
    end else if (addr_q == ADDR_IRQSTAT) begin
      HRDATA          = '0;
      HRDATA[NCH-1:0] = IRQ;
    end
  end

  assign IRQ       = exp & ie;
  assign IRQ_ANY   = |IRQ;
  assign HREADYOUT = 1'b1;

  logic unused_ok;
  assign unused_ok = ^{HADDR, HTRANS[0], HSIZE, HWDATA};

endmodule

// File: tb/tb_ahbl_mtimer.sv
// Self-checking bench for ahbl_mtimer: table-driven bus sequences with a read
// scoreboard, plus hand-timed prescaler, collision and reset sequences.
module tb_ahbl_mtimer;

  localparam int NCH = 4;

  logic           HCLK, HRESETn;
  logic [31:0]    HADDR, HWDATA, HRDATA;
  logic [1:0]     HTRANS;
  logic           HREADY, HWRITE, HSEL, HREADYOUT, IRQ_ANY;
  logic [2:0]     HSIZE;
  logic [NCH-1:0] IRQ;

  ahbl_mtimer #(.NCH(NCH), .CW(32), .PW(16)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HSEL      (HSEL),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .IRQ       (IRQ),
    .IRQ_ANY   (IRQ_ANY)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;   // write data, or expected read data
    logic [3:0]  irq;    // expected IRQ after a read
    string       name;
  } vec_t;

  vec_t        tab[$];
  vec_t        rtab[$];
  logic [31:0] sb_q[$];
  string       sbn_q[$];
  logic [31:0] wd_nxt;
  int          total = 0;
  int          bad   = 0;

  function automatic vec_t mk(bit w, logic [7:0] a, logic [31:0] d, logic [3:0] q, string n);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.irq = q; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // One bus cycle: drives this cycle's address phase and the previous write's data.
  task automatic bus(input bit act, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                     input bit chk, input logic [31:0] expv, input string name);
    HSEL   = act;
    HTRANS = act ? 2'b10 : 2'b00;
    HWRITE = wr;
    HADDR  = {24'h0, a};
    HSIZE  = 3'($urandom_range(0, 2));
    HWDATA = wd_nxt;
    wd_nxt = (act && wr) ? wd : 32'h0;
    if (act && !wr && chk) begin
      sb_q.push_back(expv);
      sbn_q.push_back(name);
    end
    @(posedge HCLK);
    #1;
    if (act && !wr && chk) check(sbn_q.pop_front(), HRDATA, sb_q.pop_front());
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus(1'b1, 1'b1, a, d, 1'b0, 32'h0, "");
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string name);
    bus(1'b1, 1'b0, a, 32'h0, 1'b1, e, name);
  endtask

  task automatic peek(input logic [7:0] a);
    bus(1'b1, 1'b0, a, 32'h0, 1'b0, 32'h0, "");
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, "");
  endtask

  task automatic run_tab();
    foreach (tab[k]) begin
      if (tab[k].wr) begin
        wr(tab[k].addr, tab[k].data);
      end else begin
        rd(tab[k].addr, tab[k].data, tab[k].name);
        check({tab[k].name, "_irq"}, 32'(IRQ), 32'(tab[k].irq));
        check({tab[k].name, "_any"}, 32'(IRQ_ANY), 32'(|tab[k].irq));
      end
    end
    tab.delete();
  endtask

  initial begin : main
    int  lat;
    bit  irq1_seen;

    HRESETn = 1'b0; HREADY = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = 32'h0; HWDATA = 32'h0; HSIZE = 3'b010; wd_nxt = 32'h0;

    rtab.push_back(mk(0, 8'h00, 32'h0, 4'h0, "rst_ctrl0"));
    rtab.push_back(mk(0, 8'h04, 32'h0, 4'h0, "rst_load0"));
    rtab.push_back(mk(0, 8'h08, 32'h0, 4'h0, "rst_count0"));
    rtab.push_back(mk(0, 8'h0C, 32'h0, 4'h0, "rst_stat0"));
    rtab.push_back(mk(0, 8'h30, 32'h0, 4'h0, "rst_ctrl3"));
    rtab.push_back(mk(0, 8'h38, 32'h0, 4'h0, "rst_count3"));
    rtab.push_back(mk(0, 8'h3C, 32'h0, 4'h0, "rst_stat3"));
    rtab.push_back(mk(0, 8'h80, 32'h0, 4'h0, "rst_prescale"));
    rtab.push_back(mk(0, 8'h84, 32'h0, 4'h0, "rst_irqstat"));
    rtab.push_back(mk(0, 8'h90, 32'hBADD_BEEF, 4'h0, "dec_90"));
    rtab.push_back(mk(0, 8'h40, 32'hBADD_BEEF, 4'h0, "dec_ch4"));
    rtab.push_back(mk(0, 8'h70, 32'hBADD_BEEF, 4'h0, "dec_ch7"));
    rtab.push_back(mk(0, 8'h02, 32'hBADD_BEEF, 4'h0, "dec_unaligned"));

    repeat (3) @(posedge HCLK);
    #1;
    check("inrst_hreadyout", 32'(HREADYOUT), 32'h1);
    check("inrst_irq", {27'h0, IRQ_ANY, IRQ}, 32'h0);
    HRESETn = 1'b1;
    idle();
    tab = rtab;
    run_tab();

    // Periodic ch0, PRESCALE=0, LOAD=3: expiry 4 cycles after CTRL data phase
    tab.push_back(mk(1, 8'h04, 32'h3, 4'h0, ""));
    tab.push_back(mk(1, 8'h00, 32'h7, 4'h0, ""));
    tab.push_back(mk(0, 8'h08, 32'h3, 4'h0, "p_cnt3"));
    tab.push_back(mk(0, 8'h08, 32'h2, 4'h0, "p_cnt2"));
    tab.push_back(mk(0, 8'h08, 32'h1, 4'h0, "p_cnt1"));
    tab.push_back(mk(0, 8'h08, 32'h0, 4'h0, "p_cnt0"));
    tab.push_back(mk(0, 8'h08, 32'h3, 4'h1, "p_reload"));
    tab.push_back(mk(1, 8'h0C, 32'h1, 4'h0, ""));
    tab.push_back(mk(0, 8'h0C, 32'h0, 4'h0, "p_w1c"));
    tab.push_back(mk(0, 8'h0C, 32'h0, 4'h0, "p_wait"));
    tab.push_back(mk(0, 8'h0C, 32'h1, 4'h1, "p_recur"));
    tab.push_back(mk(0, 8'h84, 32'h1, 4'h1, "p_irqstat"));
    tab.push_back(mk(1, 8'h00, 32'h0, 4'h0, ""));
    tab.push_back(mk(1, 8'h0C, 32'h1, 4'h0, ""));
    tab.push_back(mk(0, 8'h0C, 32'h0, 4'h0, "p_off_stat"));
    tab.push_back(mk(0, 8'h00, 32'h0, 4'h0, "p_off_ctrl"));
    tab.push_back(mk(0, 8'h08, 32'h1, 4'h0, "p_off_count"));
    run_tab();

    // ch3 LOAD=0 periodic expires on every tick, so any W1C collides with a set
    wr(8'h34, 32'h0);
    wr(8'h30, 32'h3);
    idle();
    idle();
    wr(8'h3C, 32'h1);
    rd(8'h3C, 32'h1, "collide_set_wins");
    check("collide_irq", 32'(IRQ), 32'h0);
    wr(8'h30, 32'h0);
    wr(8'h3C, 32'h1);
    rd(8'h3C, 32'h0, "collide_w1c_idle");

    // ch2: LOAD rewrite mid-period, then freeze with EN=0 and restart
    tab.push_back(mk(1, 8'h24, 32'd5, 4'h0, ""));
    tab.push_back(mk(1, 8'h20, 32'h3, 4'h0, ""));
    tab.push_back(mk(1, 8'h24, 32'd100, 4'h0, ""));
    tab.push_back(mk(0, 8'h28, 32'd4, 4'h0, "m_cnt4"));
    tab.push_back(mk(0, 8'h28, 32'd3, 4'h0, "m_cnt3"));
    tab.push_back(mk(0, 8'h28, 32'd2, 4'h0, "m_cnt2"));
    tab.push_back(mk(0, 8'h28, 32'd1, 4'h0, "m_cnt1"));
    tab.push_back(mk(0, 8'h28, 32'd0, 4'h0, "m_cnt0"));
    tab.push_back(mk(0, 8'h28, 32'd100, 4'h0, "m_reload100"));
    tab.push_back(mk(0, 8'h28, 32'd99, 4'h0, "m_cnt99"));
    tab.push_back(mk(0, 8'h24, 32'd100, 4'h0, "m_load"));
    tab.push_back(mk(1, 8'h20, 32'h0, 4'h0, ""));
    tab.push_back(mk(1, 8'h24, 32'd4, 4'h0, ""));
    tab.push_back(mk(1, 8'h20, 32'h3, 4'h0, ""));
    tab.push_back(mk(0, 8'h28, 32'd4, 4'h0, "f_start4"));
    tab.push_back(mk(0, 8'h28, 32'd3, 4'h0, "f_cnt3"));
    tab.push_back(mk(1, 8'h20, 32'hFFFF_FFFA, 4'h0, ""));
    tab.push_back(mk(0, 8'h28, 32'd2, 4'h0, "f_frozen2"));
    tab.push_back(mk(0, 8'h28, 32'd2, 4'h0, "f_hold2"));
    tab.push_back(mk(0, 8'h20, 32'h2, 4'h0, "f_ctrl_trunc"));
    tab.push_back(mk(0, 8'h28, 32'd2, 4'h0, "f_still2"));
    tab.push_back(mk(1, 8'h20, 32'h3, 4'h0, ""));
    tab.push_back(mk(0, 8'h28, 32'd4, 4'h0, "f_restart"));
    tab.push_back(mk(1, 8'h20, 32'h0, 4'h0, ""));
    run_tab();
    idle();

    // One-shot ch1: CTRL commit lands exactly on a prescaler wrap, so expiry is 3*10 cycles later
    wr(8'h14, 32'h2);
    wr(8'h80, 32'h1234_0009);
    idle();
    repeat (8) idle();
    wr(8'h10, 32'h1);
    lat = -1;
    irq1_seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      peek(8'h1C);
      if (IRQ[1]) irq1_seen = 1'b1;
      if (HRDATA[0]) begin
        lat = n;
        break;
      end
    end
    check("oneshot_latency", 32'(lat), 32'd30);
    check("oneshot_irq1_low", 32'(irq1_seen), 32'h0);
    rd(8'h10, 32'h0, "oneshot_en_clr");
    rd(8'h18, 32'h0, "oneshot_count0");
    repeat (12) idle();
    rd(8'h18, 32'h0, "oneshot_hold0");
    rd(8'h80, 32'h9, "prescale_trunc");

    // ch0 and ch3 started one cycle apart inside one prescale period expire together
    wr(8'h80, 32'h3);
    wr(8'h04, 32'h1);
    wr(8'h34, 32'h1);
    idle();
    wr(8'h00, 32'h7);
    wr(8'h30, 32'h7);
    rd(8'h84, 32'h0, "simul_pre");
    repeat (5) idle();
    rd(8'h84, 32'h0, "simul_before");
    rd(8'h84, 32'h9, "simul_irqstat");
    check("simul_irq", 32'(IRQ), 32'h9);
    check("simul_any", 32'(IRQ_ANY), 32'h1);

    // Mid-count reset pulse of one cycle
    HRESETn = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    wd_nxt = 32'h0;
    #2;
    check("midrst_irq", {27'h0, IRQ_ANY, IRQ}, 32'h0);
    check("midrst_hreadyout", 32'(HREADYOUT), 32'h1);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    idle();
    tab = rtab;
    run_tab();
    repeat (10) idle();
    rd(8'h08, 32'h0, "norun_count0");
    rd(8'h38, 32'h0, "norun_count3");
    check("norun_any", 32'(IRQ_ANY), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
